// File: rtl/dvsd_pe_pkg.sv
// Shared definitions for the registered priority encoder family.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dvsd_pe_pkg;

    // Selection policy for the grant picker.
    typedef enum logic {
        PE_MODE_FIXED = 1'b0,   // highest pending index always wins
        PE_MODE_RR    = 1'b1    // rotate downward from the last granted index
    } pe_mode_t;

endpackage

// File: rtl/dvsd_pe_pick.sv
// Combinational picker: first set bit of vec searching downward from start, wrapping modulo WIDTH.
// Latency: zero (pure combinational).
// Backpressure: none; the caller decides whether the result is consumed.
module dvsd_pe_pick #(
    parameter  int WIDTH = 8,
    localparam int OUT_W = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] vec,
    input  logic [OUT_W-1:0] start,
    output logic             found,
    output logic [OUT_W-1:0] idx
);

    // Walk the ring from the far end back towards start so the position
    // closest to start (first in search order) is the last one written.
    always_comb begin
        int pos;
        pos   = 0;
        found = 1'b0;
        idx   = '0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            pos = (int'(start) - k + WIDTH) % WIDTH;
            if (vec[pos]) begin
                found = 1'b1;
                idx   = OUT_W'(pos);
            end
        end
    end

endmodule

// File: rtl/dvsd_pe_rr.sv
// Registered priority encoder: sticky pending bits, one encoded grant per valid/ready handshake.
// Latency: request sampled at edge N sets pending; grant appears on out/out_valid at edge N+1.
// Backpressure: out/out_valid/ptr hold while out_valid & ~out_ready; request capture continues.
module dvsd_pe_rr
    import dvsd_pe_pkg::*;
#(
    parameter int       WIDTH = 8,
    parameter pe_mode_t MODE  = PE_MODE_FIXED,
    parameter int       OUT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [OUT_W-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gs,
    output logic             eno,
    output logic [WIDTH-1:0] pending
);

    logic [WIDTH-1:0] pending_q, pending_d;
    logic [OUT_W-1:0] out_q, out_d;
    logic [OUT_W-1:0] ptr_q, ptr_d;
    logic             out_valid_q, out_valid_d;
    logic             gs_q, gs_d;

    logic [OUT_W-1:0] start_idx;
    logic             pick_found;
    logic [OUT_W-1:0] pick_idx;
    logic             slot_free;
    logic             load;
    logic [WIDTH-1:0] clr;

    // Search origin: fixed mode always starts at the top; round-robin starts
    // just below the last grant so that index is visited last.
    always_comb begin
        start_idx = OUT_W'(WIDTH - 1);
        if (MODE == PE_MODE_RR) begin
            start_idx = (ptr_q == '0) ? OUT_W'(WIDTH - 1) : (ptr_q - OUT_W'(1));
        end
    end

    dvsd_pe_pick #(
        .WIDTH (WIDTH)
    ) u_pick (
        .vec   (pending_q),
        .start (start_idx),
        .found (pick_found),
        .idx   (pick_idx)
    );

    // Next-state: load a grant when the slot frees up, clear its pending bit,
    // then OR in new captures so a re-request on the same edge re-pends.
    always_comb begin
        slot_free = ~out_valid_q | out_ready;
        load      = slot_free & pick_found;

        clr = '0;
        if (load) begin
            clr[pick_idx] = 1'b1;
        end

        pending_d = (pending_q & ~clr) | (en ? in : '0);
        gs_d      = |pending_d;

        out_d       = out_q;
        out_valid_d = out_valid_q;
        ptr_d       = ptr_q;
        if (slot_free) begin
            out_valid_d = pick_found;
            if (pick_found) begin
                out_d = pick_idx;
                ptr_d = pick_idx;
            end
        end
    end

    // State registers; reset discards every pending request and in-flight grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_q   <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
            gs_q        <= 1'b0;
        end else begin
            pending_q   <= pending_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
            gs_q        <= gs_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign pending   = pending_q;
    assign gs        = gs_q;
    // Cascade enable: only en is live here, the rest are flop outputs.
    assign eno       = en & ~gs_q & ~out_valid_q;

endmodule

// File: doc/dvsd_pe_rr.md
# dvsd_pe_rr

Parametrised, registered successor to the 8:3 priority encoder: captures WIDTH request lines into sticky pending bits and emits one encoded index per grant over a valid/ready handshake. Selection is fixed-priority (highest index wins, like the combinational encoder) or round-robin. It sits between request sources and a single consumer; `gs`/`eno` keep their cascade meaning.

## Interface
- `WIDTH`, 8: number of request lines, ≥ 2.
- `MODE`, 0: 0 = fixed priority (highest index first); 1 = round-robin.
- `OUT_W`, $clog2(WIDTH): derived index width; not overridden.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  capture enable; `in` is ignored when low.
- `in`  in  WIDTH  request lines, level-sampled each edge.
- `out`  out  OUT_W  granted index, registered.
- `out_valid`  out  1  `out` holds a grant.
- `out_ready`  in  1  consumer accepts the grant when `out_valid` is also high.
- `gs`  out  1  group signal: any pending bit set (|pending).
- `eno`  out  1  en & ~gs & ~out_valid (idle, cascade enable).
- `pending`  out  WIDTH  sticky pending register, for debug.

## Operation
- Capture: each edge, pending ← (pending & ~clr) | (en ? in : 0). `clr` is the one-hot bit of the index loaded this edge. If a bit is set and cleared on the same edge, the set wins (re-pend).
- Load: when the output slot is free (~out_valid, or out_valid & out_ready), the picker searches the `pending` register (not `in`). If a bit is found, `out` ← index, `out_valid` ← 1 and that bit is cleared. If none is found, `out_valid` ← 0 and `out` holds its last value.
- Fixed mode: search from WIDTH-1 down to 0.
- Round-robin mode: `ptr` (OUT_W bits) holds the last granted index. Search from ptr-1 down, wrapping modulo WIDTH, and ending at ptr. `ptr` updates on every load. After reset ptr = 0, so the first search starts at WIDTH-1. With a single pending bit, both modes give the same result.
- Backpressure: while out_valid & ~out_ready, `out`, `out_valid` and `ptr` hold. Capture continues.
- en low: no new captures. Pending bits already held keep draining. `eno` = 0.
- Index arithmetic is modulo WIDTH when WIDTH is not a power of two. `out` never exceeds WIDTH-1.

## Timing
- Reset values (asserted asynchronously, immediately): pending = 0, out = 0, out_valid = 0, ptr = 0. This gives gs = 0 and eno = en.
- Latency: request high before edge 1 → pending set at edge 1 (gs = 1) → out/out_valid at edge 2.
- Throughput: one grant per cycle while out_ready = 1 and pending ≠ 0.
- Reset mid-operation: all in-flight grants and pending bits are discarded. No grant is issued until 2 edges after rst deasserts and a request is captured.
- `gs` and `pending` are flop outputs. `eno` is combinational from `en` and flops only. No combinational path from `in` to any output.

## Structure
- Package `dvsd_pe_pkg` holds:
  - `PE_MODE_FIXED` = 0 and `PE_MODE_RR` = 1.
  - The `pe_mode_t` typedef.
- Sub-module `dvsd_pe_pick` is purely combinational:
  - Parameters: WIDTH.
  - Inputs: vector and start index.
  - Outputs: found and index.
  - Implements a descending wrap-around search from start.
  - Fixed mode ties start to WIDTH-1. Round-robin drives start with ptr-1.
- Top level holds the pending register, the output register and `ptr`.

## Test plan
- Reset: rst = 1 with in = 8'hFF, en = 1 → out = 0, out_valid = 0, pending = 0, gs = 0, eno = 1. All hold until rst = 0.
- Single request (MODE 0): in = 8'b00000100 for one cycle, out_ready = 1 → edge 1: pending = 8'h04, gs = 1. Edge 2: out = 2, out_valid = 1, pending = 0. Edge 3: out_valid = 0, eno = 1.
- Fixed priority: in = 8'b10010001 for one cycle, out_ready = 1 → grants 7, 4, 0 on consecutive cycles, then out_valid = 0.
- Backpressure: in = 8'h81 pulse, out_ready = 0 → out = 7 held with pending = 8'h01 for 5 cycles. Then out_ready = 1 → next grant is 0.
- Round-robin (MODE 1): en = 1, in = 8'hFF held, out_ready = 1 → grants 7, 6, 5, 4, 3, 2, 1, 0, 7, …; pending stays 8'hFF (set wins). Same with in = 8'hFF and en = 0 → pending stays 0, out_valid = 0, eno = 0.
- Async reset mid-stream: pending = 8'h30 and out_valid = 1 (out = 5), then pulse rst between edges → outputs reset immediately. After release with in = 8'h30 held → first grant is 5 (ptr restarted at 0).
